// File: rtl/i_decode_pkg.sv
// Shared decode constants for the MIPS ID stage.
// Opcodes, control-vector widths and WB/M/EX bit positions.
package i_decode_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 32;

  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 3;
  localparam int unsigned EX_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // WB = {RegWrite, MemtoReg}
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  // M = {Branch, MemRead, MemWrite}
  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  // EX = {RegDst, ALUOp[1:0], ALUSrc}
  localparam int unsigned EX_REGDST = 3;
  localparam int unsigned EX_ALUOP1 = 2;
  localparam int unsigned EX_ALUOP0 = 1;
  localparam int unsigned EX_ALUSRC = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

endpackage

// File: rtl/i_decode_regfile.sv
// 32x32 register file: 2 combinational read ports with write bypass,
// 1 write port; async active-high reset clears every entry (R0 included).
module i_decode_regfile
  import i_decode_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-before-read: a same-cycle write is visible on the read ports.
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
  end

endmodule

// File: rtl/i_decode.sv
// MIPS ID stage: control decode, register read, sign-extend, ID/EX latch.
// Inputs from IF/ID and MEM/WB; outputs are the registered ID/EX bundle.
module i_decode
  import i_decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite,
  input  logic [DW-1:0]   IF_ID_instr,
  input  logic [DW-1:0]   IF_ID_NPC,
  input  logic [AW-1:0]   MEM_WB_Writereg,
  input  logic [DW-1:0]   MEM_WB_Writedata,
  output logic [WB_W-1:0] WB,
  output logic [M_W-1:0]  M,
  output logic [EX_W-1:0] EX,
  output logic [DW-1:0]   NPC,
  output logic [DW-1:0]   rdata1out,
  output logic [DW-1:0]   rdata2out,
  output logic [DW-1:0]   IR,
  output logic [AW-1:0]   instrout_2016,
  output logic [AW-1:0]   instrout_1511
);

  logic [5:0]    opcode;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] sext;
  ctrl_t         ctrl;

  assign opcode = IF_ID_instr[31:26];
  assign rs     = IF_ID_instr[25:21];
  assign rt     = IF_ID_instr[20:16];
  assign rd     = IF_ID_instr[15:11];
  assign sext   = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  i_decode_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWrite),
    .waddr  (MEM_WB_Writereg),
    .wdata  (MEM_WB_Writedata),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Unknown opcodes decode to an all-zero bubble.
  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.wb[WB_REGWRITE] = 1'b1;
        ctrl.ex[EX_REGDST]   = 1'b1;
        ctrl.ex[EX_ALUOP1]   = 1'b1;
      end
      (opcode == OP_LW): begin
        ctrl.wb[WB_REGWRITE] = 1'b1;
        ctrl.wb[WB_MEMTOREG] = 1'b1;
        ctrl.m[M_MEMREAD]    = 1'b1;
        ctrl.ex[EX_ALUSRC]   = 1'b1;
      end
      (opcode == OP_SW): begin
        ctrl.m[M_MEMWRITE]   = 1'b1;
        ctrl.ex[EX_ALUSRC]   = 1'b1;
      end
      (opcode == OP_BEQ): begin
        ctrl.m[M_BRANCH]     = 1'b1;
        ctrl.ex[EX_ALUOP0]   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB            <= '0;
      M             <= '0;
      EX            <= '0;
      NPC           <= '0;
      rdata1out     <= '0;
      rdata2out     <= '0;
      IR            <= '0;
      instrout_2016 <= '0;
      instrout_1511 <= '0;
    end else begin
      WB            <= ctrl.wb;
      M             <= ctrl.m;
      EX            <= ctrl.ex;
      NPC           <= IF_ID_NPC;
      rdata1out     <= rdata1;
      rdata2out     <= rdata2;
      IR            <= sext;
      instrout_2016 <= rt;
      instrout_1511 <= rd;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: a reference model predicts each ID/EX
// bundle, a monitor compares one edge later.
module tb_i_decode;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_NPC;
  logic [4:0]  MEM_WB_Writereg;
  logic [31:0] MEM_WB_Writedata;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [3:0]  EX;
  logic [31:0] NPC;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] IR;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;

  i_decode dut (
    .clk              (clk),
    .rst              (rst),
    .RegWrite         (RegWrite),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_NPC        (IF_ID_NPC),
    .MEM_WB_Writereg  (MEM_WB_Writereg),
    .MEM_WB_Writedata (MEM_WB_Writedata),
    .WB               (WB),
    .M                (M),
    .EX               (EX),
    .NPC              (NPC),
    .rdata1out        (rdata1out),
    .rdata2out        (rdata2out),
    .IR               (IR),
    .instrout_2016    (instrout_2016),
    .instrout_1511    (instrout_1511)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ir;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mreg [32];
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: read the architectural register state, honour the
  // same-cycle write, and look the control up in the opcode table.
  function automatic exp_t predict(input logic [31:0] instr,
                                   input logic [31:0] npc,
                                   input logic we, input logic [4:0] wr,
                                   input logic [31:0] wd);
    exp_t e;
    int   rs;
    int   rt;
    rs = int'(instr[25:21]);
    rt = int'(instr[20:16]);
    e.r1 = (we && int'(wr) == rs) ? wd : mreg[rs];
    e.r2 = (we && int'(wr) == rt) ? wd : mreg[rt];
    case (int'(instr[31:26]))
      0:  begin e.wb = 2'b10; e.m = 3'b000; e.ex = 4'b1100; end
      35: begin e.wb = 2'b11; e.m = 3'b010; e.ex = 4'b0001; end
      43: begin e.wb = 2'b00; e.m = 3'b001; e.ex = 4'b0001; end
      4:  begin e.wb = 2'b00; e.m = 3'b100; e.ex = 4'b0010; end
      default: begin e.wb = 2'b00; e.m = 3'b000; e.ex = 4'b0000; end
    endcase
    e.npc = npc;
    e.ir  = 32'(signed'(instr[15:0]));
    e.rt  = instr[20:16];
    e.rd  = instr[15:11];
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc,
                       input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
    @(negedge clk);
    IF_ID_instr      = instr;
    IF_ID_NPC        = npc;
    RegWrite         = we;
    MEM_WB_Writereg  = wr;
    MEM_WB_Writedata = wd;
    sb.push_back(predict(instr, npc, we, wr, wd));
    @(posedge clk);
    if (we) mreg[wr] = wd;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      chk($sformatf("wb#%0d", txn), 32'(WB), 32'(e.wb));
      chk($sformatf("m#%0d", txn), 32'(M), 32'(e.m));
      chk($sformatf("ex#%0d", txn), 32'(EX), 32'(e.ex));
      chk($sformatf("npc#%0d", txn), NPC, e.npc);
      chk($sformatf("rdata1#%0d", txn), rdata1out, e.r1);
      chk($sformatf("rdata2#%0d", txn), rdata2out, e.r2);
      chk($sformatf("ir#%0d", txn), IR, e.ir);
      chk($sformatf("rt#%0d", txn), 32'(instrout_2016), 32'(e.rt));
      chk($sformatf("rd#%0d", txn), 32'(instrout_1511), 32'(e.rd));
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_wb"}, 32'(WB), 0);
    chk({tag, "_m"}, 32'(M), 0);
    chk({tag, "_ex"}, 32'(EX), 0);
    chk({tag, "_npc"}, NPC, 0);
    chk({tag, "_rdata1"}, rdata1out, 0);
    chk({tag, "_rdata2"}, rdata2out, 0);
    chk({tag, "_ir"}, IR, 0);
    chk({tag, "_rt"}, 32'(instrout_2016), 0);
    chk({tag, "_rd"}, 32'(instrout_1511), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    logic [5:0]  ops [4];
    ops = '{6'd0, 6'd35, 6'd43, 6'd4};
    v = $urandom;
    if ($urandom_range(0, 4) != 0) v[31:26] = ops[$urandom_range(0, 3)];
    return v;
  endfunction

  task automatic rand_op(input bit allow_we);
    drive(rand_instr(), $urandom, allow_we ? 1'($urandom) : 1'b0,
          5'($urandom), $urandom);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    rst = 1'b1;
    RegWrite = 1'b0;
    IF_ID_instr = '0;
    IF_ID_NPC = '0;
    MEM_WB_Writereg = '0;
    MEM_WB_Writedata = '0;
    #3;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive(32'hFC00_0000, 32'h0000_0004, 1'b1, 5'd0, 32'h0023_00AA);
    drive(32'hFC00_0000, 32'h0000_0008, 1'b1, 5'd1, 32'h1065_4321);
    drive(32'h0001_0000, 32'h0000_000C, 1'b0, 5'd0, 32'h0);
    drive(32'h8C12_3456, 32'h0000_0010, 1'b0, 5'd0, 32'h0);
    drive(32'hAD65_4321, 32'h0000_0014, 1'b0, 5'd0, 32'h0);
    drive(32'h1001_8000, 32'h0000_0018, 1'b0, 5'd0, 32'h0);
    drive(32'hFC00_0000, 32'h0000_001C, 1'b1, 5'd3, 32'h1234_5678);
    drive(32'h0060_0000, 32'h0000_0020, 1'b0, 5'd3, 32'hDEAD_BEEF);
    drive(32'h0060_0000, 32'h0000_0024, 1'b0, 5'd0, 32'h0);
    drive(32'h00A0_0000, 32'h0000_0028, 1'b1, 5'd5, 32'hCAFE_F00D);
    drive(32'h00A5_0000, 32'h0000_002C, 1'b0, 5'd0, 32'h0);

    for (int i = 0; i < 400; i++) rand_op(1'b1);

    @(negedge clk);
    RegWrite = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;

    for (int i = 0; i < 20; i++) rand_op(1'b0);
    for (int i = 0; i < 100; i++) rand_op(1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
